// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control tokens, decoder FSM states, data-word decode.
package tmds_pkg;

    localparam logic [9:0] TMDS_TOKEN_00 = 10'b1101010100;
    localparam logic [9:0] TMDS_TOKEN_01 = 10'b0010101011;
    localparam logic [9:0] TMDS_TOKEN_10 = 10'b0101010100;
    localparam logic [9:0] TMDS_TOKEN_11 = 10'b1010101011;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_SLIP   = 2'd1,
        ST_WAIT   = 2'd2,
        ST_LOCKED = 2'd3
    } tmds_state_e;

    // Undo the optional inversion, then the XOR/XNOR transition chain.
    function automatic logic [7:0] tmds_decode_data(input logic [9:0] word);
        logic [7:0] q;
        logic [7:0] d;
        q    = word[9] ? ~word[7:0] : word[7:0];
        d    = '0;
        d[0] = q[0];
        for (int i = 1; i < 8; i++) begin
            d[i] = word[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        end
        return d;
    endfunction

endpackage

// File: rtl/tmds_word_decode.sv
// Combinational classification of one 10-bit TMDS word: token match plus data decode.
module tmds_word_decode
    import tmds_pkg::*;
(
    input  logic [9:0] din,
    output logic       is_token_c,
    output logic [1:0] ctrl_c,
    output logic [7:0] data_c
);

    // Token lookup; anything that is not one of the four tokens is data.
    always_comb begin
        is_token_c = 1'b1;
        ctrl_c     = 2'b00;
        data_c     = tmds_decode_data(din);
        case (din)
            TMDS_TOKEN_00: ctrl_c = 2'b00;
            TMDS_TOKEN_01: ctrl_c = 2'b01;
            TMDS_TOKEN_10: ctrl_c = 2'b10;
            TMDS_TOKEN_11: ctrl_c = 2'b11;
            default:       is_token_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/tmds_decoder.sv
// Single-channel TMDS receiver: word alignment by bit-slip search, then token/data decode.
// Optional statistics counters (SLIP_CNT, LOSS_CNT) are built when TMDS_DEC_STATS_EN is defined.
module tmds_decoder
    import tmds_pkg::*;
#(
    parameter int unsigned CTRL_RUN    = 8,
    parameter int unsigned LOCK_BLANKS = 4,
    parameter int unsigned TMO_W       = 12,
    parameter int unsigned SLIP_WAIT   = 3
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [9:0] DIN,
    output logic       BITSLIP,
    output logic       ALIGNED,
    output logic [7:0] DOUT,
    output logic [1:0] C,
    output logic       DE,
    output logic [7:0] SLIP_CNT,
    output logic [7:0] LOSS_CNT
);

    localparam int unsigned RUN_W   = $clog2(CTRL_RUN + 1);
    localparam int unsigned BLANK_W = $clog2(LOCK_BLANKS + 1);
    localparam int unsigned WAIT_W  = $clog2(SLIP_WAIT + 1);

    logic       is_token_c;
    logic [1:0] ctrl_c;
    logic [7:0] data_c;

    tmds_word_decode u_word_decode (
        .din        (DIN),
        .is_token_c (is_token_c),
        .ctrl_c     (ctrl_c),
        .data_c     (data_c)
    );

    tmds_state_e        state_q,   state_d;
    logic [RUN_W-1:0]   run_q,     run_d;
    logic [BLANK_W-1:0] blank_q,   blank_d;
    logic [TMO_W-1:0]   tmo_q,     tmo_d;
    logic [WAIT_W-1:0]  wait_q,    wait_d;
    logic               bitslip_q, bitslip_d;
    logic               aligned_q, aligned_d;
    logic [7:0]         dout_q,    dout_d;
    logic [1:0]         c_q,       c_d;
    logic               de_q,      de_d;

    logic               blank_evt_c;
    logic               tmo_exp_c;
    logic [RUN_W-1:0]   run_upd_c;

    // Blanking qualification: the token that brings the run to CTRL_RUN; run saturates after.
    always_comb begin
        blank_evt_c = is_token_c && (run_q == RUN_W'(CTRL_RUN - 1));
        tmo_exp_c   = (tmo_q == {TMO_W{1'b1}});
        run_upd_c   = '0;
        if (is_token_c) begin
            run_upd_c = (run_q == RUN_W'(CTRL_RUN)) ? run_q : run_q + RUN_W'(1);
        end
    end

    // Alignment FSM next state, counters and registered decode outputs.
    always_comb begin
        state_d   = state_q;
        run_d     = run_q;
        blank_d   = blank_q;
        tmo_d     = tmo_q;
        wait_d    = wait_q;
        bitslip_d = 1'b0;
        aligned_d = 1'b0;
        dout_d    = 8'h00;
        c_d       = 2'b00;
        de_d      = 1'b0;

        case (state_q)
            ST_SEARCH: begin
                run_d = run_upd_c;
                if (blank_evt_c) begin
                    tmo_d   = '0;
                    blank_d = blank_q + BLANK_W'(1);
                    if (blank_q == BLANK_W'(LOCK_BLANKS - 1)) begin
                        state_d = ST_LOCKED;
                    end
                end else if (tmo_exp_c) begin
                    state_d = ST_SLIP;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_SLIP: begin
                run_d   = '0;
                blank_d = '0;
                tmo_d   = '0;
                wait_d  = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_q == WAIT_W'(SLIP_WAIT - 1)) begin
                    wait_d  = '0;
                    state_d = ST_SEARCH;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_LOCKED: begin
                run_d = run_upd_c;
                if (blank_evt_c) begin
                    tmo_d = '0;
                end else if (tmo_exp_c) begin
                    tmo_d   = '0;
                    blank_d = '0;
                    state_d = ST_SEARCH;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: state_d = ST_SEARCH;
        endcase

        bitslip_d = (state_d == ST_SLIP);
        aligned_d = (state_d == ST_LOCKED);
        if (aligned_d) begin
            if (is_token_c) begin
                c_d = ctrl_c;
            end else begin
                de_d   = 1'b1;
                dout_d = data_c;
                c_d    = c_q;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= ST_SEARCH;
            run_q     <= '0;
            blank_q   <= '0;
            tmo_q     <= '0;
            wait_q    <= '0;
            bitslip_q <= 1'b0;
            aligned_q <= 1'b0;
            dout_q    <= 8'h00;
            c_q       <= 2'b00;
            de_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_q     <= run_d;
            blank_q   <= blank_d;
            tmo_q     <= tmo_d;
            wait_q    <= wait_d;
            bitslip_q <= bitslip_d;
            aligned_q <= aligned_d;
            dout_q    <= dout_d;
            c_q       <= c_d;
            de_q      <= de_d;
        end
    end

    assign BITSLIP = bitslip_q;
    assign ALIGNED = aligned_q;
    assign DOUT    = dout_q;
    assign C       = c_q;
    assign DE      = de_q;

`ifdef TMDS_DEC_STATS_EN
    logic [7:0] slip_cnt_q, slip_cnt_d;
    logic [7:0] loss_cnt_q, loss_cnt_d;

    // Saturating counts of slip requests and lock losses.
    always_comb begin
        slip_cnt_d = slip_cnt_q;
        loss_cnt_d = loss_cnt_q;
        if ((state_q == ST_SEARCH) && (state_d == ST_SLIP) && (slip_cnt_q != 8'hFF)) begin
            slip_cnt_d = slip_cnt_q + 8'd1;
        end
        if ((state_q == ST_LOCKED) && (state_d == ST_SEARCH) && (loss_cnt_q != 8'hFF)) begin
            loss_cnt_d = loss_cnt_q + 8'd1;
        end
    end

    // Statistics registers, cleared only by reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            slip_cnt_q <= 8'h00;
            loss_cnt_q <= 8'h00;
        end else begin
            slip_cnt_q <= slip_cnt_d;
            loss_cnt_q <= loss_cnt_d;
        end
    end

    assign SLIP_CNT = slip_cnt_q;
    assign LOSS_CNT = loss_cnt_q;
`else
    assign SLIP_CNT = 8'h00;
    assign LOSS_CNT = 8'h00;
`endif

endmodule

// File: tb/tb_tmds_decoder.sv
// Bench for tmds_decoder: TMDS encoder + bit-level deserializer model feeding the DUT,
// with a cycle reference model of the alignment rules.
module tb_tmds_decoder;

    localparam int CTRL_RUN    = 8;
    localparam int LOCK_BLANKS = 4;
    localparam int TMO_W       = 12;
    localparam int SLIP_WAIT   = 3;
    localparam int TMO         = 1 << TMO_W;

`ifdef TMDS_DEC_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    localparam logic [9:0] TOK [4] = '{10'b1101010100, 10'b0010101011,
                                       10'b0101010100, 10'b1010101011};

    logic       CLK = 1'b0;
    logic       RST;
    logic [9:0] DIN;
    logic       BITSLIP;
    logic       ALIGNED;
    logic [7:0] DOUT;
    logic [1:0] C;
    logic       DE;
    logic [7:0] SLIP_CNT;
    logic [7:0] LOSS_CNT;

    always #5 CLK = ~CLK;

    tmds_decoder #(
        .CTRL_RUN    (CTRL_RUN),
        .LOCK_BLANKS (LOCK_BLANKS),
        .TMO_W       (TMO_W),
        .SLIP_WAIT   (SLIP_WAIT)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .DIN      (DIN),
        .BITSLIP  (BITSLIP),
        .ALIGNED  (ALIGNED),
        .DOUT     (DOUT),
        .C        (C),
        .DE       (DE),
        .SLIP_CNT (SLIP_CNT),
        .LOSS_CNT (LOSS_CNT)
    );

    int checks = 0;
    int errors = 0;

    // serial stream and the byte carried by each generated word (-1 for tokens)
    bit bits[$];
    int m_byte[$];
    int pos = 0;

    // stream generator: mode 0 = 16 tokens + 64 data, 1 = data only, 2 = 7 tokens + 64 data
    int g_mode = 0;
    int g_idx = 0;
    bit g_seq = 1'b1;
    bit g_tokmode = 1'b0;
    int disp = 0;

    logic [9:0] cur_word;
    bit         cur_aligned;
    int         cur_byte;

    // reference model
    bit m_locked;
    int m_blanks, m_quiet, m_run, m_hold, m_lastc, m_slips, m_loss, m_de;

    // per-test observations
    int cyc = 0;
    int cyc_bad, bad_cyc, slips_seen, last_slip, min_gap, de_seen;
    logic [12:0] bad_act, bad_exp;
    bit ever_aligned;
    logic [3:0] cmask;

    function automatic logic [9:0] tmds_encode(input logic [7:0] d);
        logic [8:0] qm;
        logic [9:0] o;
        int n1, n1q, n0q;
        n1 = $countones(d);
        qm = '0;
        qm[0] = d[0];
        if (n1 > 4 || (n1 == 4 && d[0] == 1'b0)) begin
            for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
            qm[8] = 1'b0;
        end else begin
            for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
            qm[8] = 1'b1;
        end
        n1q = $countones(qm[7:0]);
        n0q = 8 - n1q;
        if (disp == 0 || n1q == n0q) begin
            o[9]   = ~qm[8];
            o[8]   = qm[8];
            o[7:0] = qm[8] ? qm[7:0] : ~qm[7:0];
            if (qm[8] == 1'b0) disp += n0q - n1q;
            else               disp += n1q - n0q;
        end else if ((disp > 0 && n1q > n0q) || (disp < 0 && n0q > n1q)) begin
            o[9]   = 1'b1;
            o[8]   = qm[8];
            o[7:0] = ~qm[7:0];
            disp  += 2 * int'(qm[8]) + n0q - n1q;
        end else begin
            o[9]   = 1'b0;
            o[8]   = qm[8];
            o[7:0] = qm[7:0];
            disp  += -2 * int'(!qm[8]) + n1q - n0q;
        end
        return o;
    endfunction

    function automatic int tok_of(input logic [9:0] w);
        for (int k = 0; k < 4; k++) if (w == TOK[k]) return k;
        return -1;
    endfunction

    task automatic push_word(input logic [9:0] w, input int b);
        for (int i = 0; i < 10; i++) bits.push_back(w[i]);
        m_byte.push_back(b);
    endtask

    task automatic gen_word();
        int blen;
        int b;
        blen = (g_mode == 2) ? 7 : 16;
        if (g_mode == 1 || g_idx >= blen) begin
            b = (g_mode != 1 && g_seq) ? (g_idx - blen) : int'($urandom_range(0, 255));
            push_word(tmds_encode(8'(b)), b);
        end else begin
            disp = 0;
            push_word(TOK[g_tokmode ? (g_idx % 4) : 0], -1);
        end
        g_idx++;
        if (g_mode != 1 && g_idx >= blen + 64) g_idx = 0;
    endtask

    task automatic drive_word();
        while (bits.size() < pos + 10) gen_word();
        for (int i = 0; i < 10; i++) DIN[i] = bits[pos + i];
        cur_word    = DIN;
        cur_aligned = (pos % 10 == 0);
        cur_byte    = m_byte[pos / 10];
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_blanks = 0;
        m_quiet  = 0;
        m_run    = 0;
        m_hold   = 0;
        m_lastc  = 0;
        m_slips  = 0;
        m_loss   = 0;
    endtask

    task automatic clear_obs();
        cyc_bad      = 0;
        bad_cyc      = 0;
        slips_seen   = 0;
        last_slip    = -1;
        min_gap      = 1 << 30;
        de_seen      = 0;
        m_de         = 0;
        ever_aligned = 1'b0;
        cmask        = 4'h0;
        bad_act      = '0;
        bad_exp      = '0;
    endtask

    // One clock: model the word sampled at the edge, compare on the falling edge,
    // then advance the deserializer (one extra bit when BITSLIP is seen).
    task automatic step();
        logic [12:0] exp_v, act_v, mask;
        int  t;
        bit  qual, es;
        @(posedge CLK);
        es    = 1'b0;
        exp_v = '0;
        mask  = 13'h1FFF;
        if (RST !== 1'b1) begin
            model_reset();
        end else begin
            t = tok_of(cur_word);
            if (m_hold > 0) begin
                m_hold--;
                m_run = 0;
            end else begin
                qual  = (t >= 0) && (m_run == CTRL_RUN - 1);
                m_run = (t >= 0) ? ((m_run < CTRL_RUN) ? m_run + 1 : m_run) : 0;
                if (qual) begin
                    m_quiet = 0;
                    if (!m_locked) begin
                        m_blanks++;
                        if (m_blanks == LOCK_BLANKS) m_locked = 1'b1;
                    end
                end else if (m_quiet == TMO - 1) begin
                    m_quiet = 0;
                    if (m_locked) begin
                        m_locked = 1'b0;
                        m_blanks = 0;
                        if (m_loss < 255) m_loss++;
                    end else begin
                        es       = 1'b1;
                        m_hold   = 1 + SLIP_WAIT;
                        m_blanks = 0;
                        m_run    = 0;
                        if (m_slips < 255) m_slips++;
                    end
                end else begin
                    m_quiet++;
                end
            end
            if (m_locked) begin
                if (t >= 0) begin
                    m_lastc = t;
                    exp_v   = {1'b0, 1'b1, 1'b0, 2'(t), 8'h00};
                end else begin
                    m_de++;
                    exp_v = {1'b0, 1'b1, 1'b1, 2'(m_lastc), cur_aligned ? 8'(cur_byte) : 8'h00};
                    if (!cur_aligned) mask[7:0] = 8'h00;
                end
            end else begin
                exp_v = {es, 12'h000};
            end
        end
        @(negedge CLK);
        act_v = {BITSLIP, ALIGNED, DE, C, DOUT};
        if ($isunknown(act_v) || (((act_v ^ exp_v) & mask) != 13'h0)) begin
            if (cyc_bad == 0) begin
                bad_cyc = cyc;
                bad_act = act_v;
                bad_exp = exp_v;
            end
            cyc_bad++;
        end
        if (BITSLIP === 1'b1) begin
            slips_seen++;
            if (last_slip >= 0 && (cyc - last_slip) < min_gap) min_gap = cyc - last_slip;
            last_slip = cyc;
        end
        if (DE === 1'b1) de_seen++;
        if (ALIGNED === 1'b1) ever_aligned = 1'b1;
        if (ALIGNED === 1'b1 && DE === 1'b0) cmask[C] = 1'b1;
        pos += 10 + ((BITSLIP === 1'b1) ? 1 : 0);
        drive_word();
        cyc++;
    endtask

    task automatic do_reset();
        RST = 1'b0;
        model_reset();
        repeat (3) step();
        RST = 1'b1;
        clear_obs();
    endtask

    task automatic realign();
        pos = ((pos + 9) / 10) * 10;
        drive_word();
    endtask

    task automatic report_cycles(input string name);
        checks++;
        if (cyc_bad !== 0) begin
            errors++;
            $display("FAIL %s: %0d bad cycles, first at %0d got %0h expected %0h",
                     name, cyc_bad, bad_cyc, bad_act, bad_exp);
        end
    endtask

    task automatic test_reset();
        RST = 1'b0;
        model_reset();
        drive_word();
        repeat (3) step();
        checks++;
        if ({BITSLIP, ALIGNED, DE} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000", {BITSLIP, ALIGNED, DE});
        end
        checks++;
        if (DOUT !== 8'h00) begin
            errors++;
            $display("FAIL reset_dout: got %0h expected 00", DOUT);
        end
        checks++;
        if (C !== 2'b00) begin
            errors++;
            $display("FAIL reset_c: got %0b expected 00", C);
        end
        checks++;
        if ({SLIP_CNT, LOSS_CNT} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_stats: got %0h expected 0000", {SLIP_CNT, LOSS_CNT});
        end
        RST = 1'b1;
    endtask

    task automatic test_aligned_stream();
        do_reset();
        g_mode = 0; g_seq = 1'b1; g_tokmode = 1'b0; g_idx = 0;
        realign();
        repeat (100 * 80) step();
        report_cycles("aligned_cycles");
        checks++;
        if (ALIGNED !== 1'b1) begin
            errors++;
            $display("FAIL aligned_lock: got %b expected 1", ALIGNED);
        end
        checks++;
        if (slips_seen !== 0) begin
            errors++;
            $display("FAIL aligned_no_slip: got %0d expected 0", slips_seen);
        end
        checks++;
        if (de_seen !== m_de || de_seen < 64 * 90) begin
            errors++;
            $display("FAIL aligned_de_count: got %0d expected %0d", de_seen, m_de);
        end
    endtask

    task automatic test_all_tokens();
        do_reset();
        g_mode = 0; g_seq = 1'b0; g_tokmode = 1'b1; g_idx = 0;
        realign();
        repeat (8 * 80) step();
        report_cycles("tokens_cycles");
        checks++;
        if (cmask !== 4'hF) begin
            errors++;
            $display("FAIL tokens_c_values: got %b expected 1111", cmask);
        end
        g_tokmode = 1'b0;
    endtask

    task automatic test_bitslip();
        do_reset();
        g_mode = 0; g_seq = 1'b0; g_tokmode = 1'b0;
        pos = ((pos / 10) + 1) * 10 + 7;
        drive_word();
        for (int i = 0; i < 20000 && ALIGNED !== 1'b1; i++) step();
        repeat (300) step();
        report_cycles("slip_cycles");
        checks++;
        if (ALIGNED !== 1'b1) begin
            errors++;
            $display("FAIL slip_lock: got %b expected 1", ALIGNED);
        end
        checks++;
        if (slips_seen !== 3) begin
            errors++;
            $display("FAIL slip_count: got %0d expected 3", slips_seen);
        end
        checks++;
        if (min_gap < 1 + SLIP_WAIT + TMO) begin
            errors++;
            $display("FAIL slip_spacing: got %0d expected >= %0d", min_gap, 1 + SLIP_WAIT + TMO);
        end
        checks++;
        if (SLIP_CNT !== 8'(STATS ? 3 : 0)) begin
            errors++;
            $display("FAIL slip_stat: got %0d expected %0d", SLIP_CNT, STATS ? 3 : 0);
        end
    endtask

    task automatic test_loss();
        do_reset();
        g_mode = 0; g_seq = 1'b0; g_idx = 0;
        realign();
        repeat (6 * 80) step();
        checks++;
        if (ALIGNED !== 1'b1) begin
            errors++;
            $display("FAIL loss_initial_lock: got %b expected 1", ALIGNED);
        end
        g_mode = 1; g_idx = 0;
        repeat (TMO + 150) step();
        checks++;
        if (ALIGNED !== 1'b0) begin
            errors++;
            $display("FAIL loss_unlock: got %b expected 0", ALIGNED);
        end
        checks++;
        if (LOSS_CNT !== 8'(STATS ? 1 : 0)) begin
            errors++;
            $display("FAIL loss_stat: got %0d expected %0d", LOSS_CNT, STATS ? 1 : 0);
        end
        g_mode = 0; g_idx = 0;
        repeat (6 * 80) step();
        checks++;
        if (ALIGNED !== 1'b1 || slips_seen !== 0) begin
            errors++;
            $display("FAIL loss_relock: got aligned %b slips %0d expected aligned 1 slips 0",
                     ALIGNED, slips_seen);
        end
        report_cycles("loss_cycles");
    endtask

    task automatic test_short_runs();
        do_reset();
        g_mode = 2; g_seq = 1'b0; g_idx = 0;
        realign();
        repeat (TMO + 200) step();
        report_cycles("run7_cycles");
        checks++;
        if (ever_aligned !== 1'b0 || slips_seen !== 1) begin
            errors++;
            $display("FAIL run7_behaviour: got aligned %b slips %0d expected aligned 0 slips 1",
                     ever_aligned, slips_seen);
        end
        g_mode = 0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        g_mode = 0; g_seq = 1'b0; g_idx = 0;
        realign();
        for (int i = 0; i < 1000 && ALIGNED !== 1'b1; i++) step();
        repeat (20) step();
        #2;
        RST = 1'b0;
        #1;
        checks++;
        if ({BITSLIP, ALIGNED, DE, C, DOUT, SLIP_CNT, LOSS_CNT} !== 29'h0) begin
            errors++;
            $display("FAIL midreset_outputs: got %0h expected 0",
                     {BITSLIP, ALIGNED, DE, C, DOUT, SLIP_CNT, LOSS_CNT});
        end
        model_reset();
        repeat (2) step();
        RST = 1'b1;
        for (int i = 0; i < 1000 && ALIGNED !== 1'b1; i++) step();
        repeat (100) step();
        checks++;
        if (ALIGNED !== 1'b1) begin
            errors++;
            $display("FAIL midreset_relock: got %b expected 1", ALIGNED);
        end
        report_cycles("midreset_cycles");
    endtask

    initial begin
        clear_obs();
        model_reset();
        test_reset();
        test_aligned_stream();
        test_all_tokens();
        test_bitslip();
        test_loss();
        test_short_runs();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
